binary_threshold_hyst: RTL and testbench

BINARY_THRESHOLD_HYST -- requirements
Module: binary_threshold_hyst

---
 rtl/binary_threshold_hyst.sv | 132 +++++++++++++
 tb/tb_binary_threshold_hyst.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_threshold_hyst.sv
// Binary thresholding of a grey pixel stream with four modes (single, hysteresis,
// band, inverted) and a per-line foreground pixel count.
module binary_threshold_hyst #(
  parameter int unsigned DW         = 10,
  parameter int unsigned CW         = 12,
  parameter int unsigned TH_DEFAULT = 190
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  input  logic [DW-1:0] iTH_HI,
  input  logic [DW-1:0] iTH_LO,
  input  logic [1:0]    iMODE,
  input  logic          iCFG_LOAD,
  output logic [DW-1:0] oDATA,
  output logic          oDVAL,
  output logic [CW-1:0] oCNT,
  output logic          oCNT_VAL
);

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_HYST   = 2'd1;
  localparam logic [1:0] MODE_BAND   = 2'd2;
  localparam logic [1:0] MODE_INV    = 2'd3;

  localparam logic [DW-1:0] TH_RST  = DW'(TH_DEFAULT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // active configuration (used for classification) and pending configuration
  logic [DW-1:0] r_th_hi, r_th_lo, r_p_hi, r_p_lo;
  logic [1:0]    r_mode, r_p_mode;
  logic          r_pend;

  logic          r_fg;
  logic [CW-1:0] r_cnt;

  logic          w_above_hi;
  logic          w_le_lo;
  logic          w_fg_hyst;
  logic          w_fg;
  logic          w_line_end;
  logic          w_apply;

  assign w_above_hi = iDATA > r_th_hi;
  assign w_le_lo    = iDATA <= r_th_lo;
  assign w_line_end = !iDVAL && oDVAL;
  // pending set may only be applied between lines so no line mixes configurations
  assign w_apply    = !iDVAL && r_pend;

  // hysteresis update: the high test wins, so LO > HI behaves like single mode
  always_comb begin
    w_fg_hyst = r_fg;
    if (w_above_hi) begin
      w_fg_hyst = 1'b1;
    end else if (w_le_lo) begin
      w_fg_hyst = 1'b0;
    end
  end

  // per-pixel foreground decision, forced to background when no valid pixel
  always_comb begin
    w_fg = 1'b0;
    if (iDVAL) begin
      case (r_mode)
        MODE_SINGLE: w_fg = w_above_hi;
        MODE_HYST:   w_fg = w_fg_hyst;
        MODE_BAND:   w_fg = !w_le_lo && !w_above_hi;
        MODE_INV:    w_fg = !w_above_hi;
        default:     w_fg = 1'b0;
      endcase
    end
  end

  // configuration capture and application
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_th_hi  <= TH_RST;
      r_th_lo  <= TH_RST;
      r_mode   <= MODE_SINGLE;
      r_p_hi   <= TH_RST;
      r_p_lo   <= TH_RST;
      r_p_mode <= MODE_SINGLE;
      r_pend   <= 1'b0;
    end else begin
      if (w_apply) begin
        r_th_hi <= r_p_hi;
        r_th_lo <= r_p_lo;
        r_mode  <= r_p_mode;
        r_pend  <= 1'b0;
      end
      // a load in the same cycle as an apply stays pending for the next gap cycle
      if (iCFG_LOAD) begin
        r_p_hi   <= iTH_HI;
        r_p_lo   <= iTH_LO;
        r_p_mode <= iMODE;
        r_pend   <= 1'b1;
      end
    end
  end

  // pixel output pipeline and hysteresis state
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      oDATA <= '0;
      oDVAL <= 1'b0;
      r_fg  <= 1'b0;
    end else begin
      oDATA <= w_fg ? {DW{1'b1}} : {DW{1'b0}};
      oDVAL <= iDVAL;
      r_fg  <= iDVAL ? w_fg_hyst : 1'b0;
    end
  end

  // saturating per-line foreground counter with transfer on line end
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_cnt    <= '0;
      oCNT     <= '0;
      oCNT_VAL <= 1'b0;
    end else begin
      oCNT_VAL <= w_line_end;
      if (w_line_end) begin
        oCNT  <= r_cnt;
        r_cnt <= '0;
      end else if (w_fg && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_binary_threshold_hyst.sv
// Directed bench for binary_threshold_hyst: default instance plus a CW=4 instance
// sharing the same stimulus for the saturation case.
module tb_binary_threshold_hyst;

  localparam int unsigned DW = 10;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iDVAL;
  logic [DW-1:0] iDATA;
  logic [DW-1:0] iTH_HI;
  logic [DW-1:0] iTH_LO;
  logic [1:0]    iMODE;
  logic          iCFG_LOAD;

  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic [11:0]   oCNT;
  logic          oCNT_VAL;

  logic [DW-1:0] oDATA4;
  logic          oDVAL4;
  logic [3:0]    oCNT4;
  logic          oCNT_VAL4;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 iCLK = ~iCLK;

  binary_threshold_hyst u_dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA),
    .iTH_HI(iTH_HI), .iTH_LO(iTH_LO), .iMODE(iMODE), .iCFG_LOAD(iCFG_LOAD),
    .oDATA(oDATA), .oDVAL(oDVAL), .oCNT(oCNT), .oCNT_VAL(oCNT_VAL)
  );

  binary_threshold_hyst #(.CW(4)) u_dut4 (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA),
    .iTH_HI(iTH_HI), .iTH_LO(iTH_LO), .iMODE(iMODE), .iCFG_LOAD(iCFG_LOAD),
    .oDATA(oDATA4), .oDVAL(oDVAL4), .oCNT(oCNT4), .oCNT_VAL(oCNT_VAL4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // drive one pixel and check the registered result
  task automatic pix(input string tag, input logic [DW-1:0] d, input logic fg);
    iDVAL = 1'b1;
    iDATA = d;
    tick();
    chk({tag, "_dval"}, 32'(oDVAL), 32'd1);
    chk({tag, "_data"}, 32'(oDATA), fg ? 32'h3FF : 32'h0);
  endtask

  // end the line and check the count pulse
  task automatic line_end(input string tag, input int unsigned cnt);
    iDVAL = 1'b0;
    iDATA = '0;
    tick();
    chk({tag, "_val"}, 32'(oCNT_VAL), 32'd1);
    chk({tag, "_cnt"}, 32'(oCNT), 32'(cnt));
    chk({tag, "_odata0"}, 32'(oDATA), 32'd0);
    tick();
    chk({tag, "_val_drop"}, 32'(oCNT_VAL), 32'd0);
    chk({tag, "_cnt_hold"}, 32'(oCNT), 32'(cnt));
  endtask

  // load a configuration during an idle gap and let it apply
  task automatic load_idle(input logic [1:0] m, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    iDVAL = 1'b0;
    iMODE = m;
    iTH_HI = hi;
    iTH_LO = lo;
    iCFG_LOAD = 1'b1;
    tick();
    iCFG_LOAD = 1'b0;
    tick();
  endtask

  initial begin
    iRST = 1'b0; iDVAL = 1'b0; iDATA = '0;
    iTH_HI = '0; iTH_LO = '0; iMODE = 2'd0; iCFG_LOAD = 1'b0;
    tick();
    tick();
    chk("rst_odata", 32'(oDATA), 32'd0);
    chk("rst_odval", 32'(oDVAL), 32'd0);
    chk("rst_ocnt", 32'(oCNT), 32'd0);
    chk("rst_ocntval", 32'(oCNT_VAL), 32'd0);
    iRST = 1'b1;
    tick();

    // default threshold 190, mode 0
    pix("def189", 10'd189, 1'b0);
    pix("def190", 10'd190, 1'b0);
    pix("def191", 10'd191, 1'b1);
    pix("def1023", 10'd1023, 1'b1);
    line_end("def_end", 2);

    // hysteresis HI=200 LO=100
    load_idle(2'd1, 10'd200, 10'd100);
    pix("hys150a", 10'd150, 1'b0);
    pix("hys201", 10'd201, 1'b1);
    pix("hys150b", 10'd150, 1'b1);
    pix("hys100", 10'd100, 1'b0);
    pix("hys150c", 10'd150, 1'b0);
    line_end("hys_end", 2);

    // hysteresis state must not survive the gap: 150 starts as background
    pix("hys_carry201", 10'd201, 1'b1);
    line_end("hys_carry_end", 1);
    pix("hys_fresh150", 10'd150, 1'b0);
    line_end("hys_fresh_end", 0);

    // band LO=50 HI=60
    load_idle(2'd2, 10'd60, 10'd50);
    pix("band50", 10'd50, 1'b0);
    pix("band51", 10'd51, 1'b1);
    pix("band60", 10'd60, 1'b1);
    pix("band61", 10'd61, 1'b0);
    line_end("band_end", 2);

    // empty band LO=HI=60
    load_idle(2'd2, 10'd60, 10'd60);
    pix("eband55", 10'd55, 1'b0);
    pix("eband60", 10'd60, 1'b0);
    pix("eband61", 10'd61, 1'b0);
    line_end("eband_end", 0);

    // mode 0, then a mode-3 load mid-line must wait for the line end
    load_idle(2'd0, 10'd190, 10'd0);
    pix("mid200", 10'd200, 1'b1);
    iMODE = 2'd3; iTH_HI = 10'd190; iTH_LO = 10'd0; iCFG_LOAD = 1'b1;
    pix("mid100", 10'd100, 1'b0);
    iCFG_LOAD = 1'b0;
    pix("mid50", 10'd50, 1'b0);
    pix("mid250", 10'd250, 1'b1);
    line_end("mid_end", 2);
    pix("inv100", 10'd100, 1'b1);
    pix("inv250", 10'd250, 1'b0);
    pix("inv190", 10'd190, 1'b1);
    line_end("inv_end", 2);

    // single-pixel line still produces a count pulse
    pix("one0", 10'd0, 1'b1);
    line_end("one_end", 1);

    // saturation: 20 foreground pixels, CW=12 counts 20, CW=4 saturates at 15
    load_idle(2'd0, 10'd190, 10'd0);
    for (int i = 0; i < 20; i++) begin
      iDVAL = 1'b1;
      iDATA = 10'd500;
      tick();
    end
    chk("sat_last_data", 32'(oDATA), 32'h3FF);
    iDVAL = 1'b0;
    tick();
    chk("sat_val12", 32'(oCNT_VAL), 32'd1);
    chk("sat_cnt12", 32'(oCNT), 32'd20);
    chk("sat_val4", 32'(oCNT_VAL4), 32'd1);
    chk("sat_cnt4", 32'(oCNT4), 32'd15);
    tick();

    // reset mid-line under a non-default config: no pulse, defaults restored
    load_idle(2'd3, 10'd300, 10'd0);
    pix("rst_line_a", 10'd500, 1'b0);
    pix("rst_line_b", 10'd5, 1'b1);
    iRST = 1'b0;
    iDATA = 10'd5;
    tick();
    chk("mrst_odata", 32'(oDATA), 32'd0);
    chk("mrst_odval", 32'(oDVAL), 32'd0);
    chk("mrst_ocnt", 32'(oCNT), 32'd0);
    chk("mrst_ocntval", 32'(oCNT_VAL), 32'd0);
    iRST = 1'b1;
    iDVAL = 1'b0;
    tick();
    chk("mrst_nopulse", 32'(oCNT_VAL), 32'd0);
    tick();
    chk("mrst_nopulse2", 32'(oCNT_VAL), 32'd0);
    pix("post189", 10'd189, 1'b0);
    pix("post191", 10'd191, 1'b1);
    line_end("post_end", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // bound the whole run so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
